// File: rtl/mul_iter_param.sv
// Purpose : iterative shift-add multiplier with MUL/MADD/MSUB modes and flush.
// Latency : N+1 edges after the start edge, with N = WIDTH/BITS_PER_CYCLE. ready_o is high in the cycle after that.
// Backpr. : result and ready_o are held while start_i stays high. Dropping start_i releases the unit.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start_i             request; sampled in IDLE; keep high until the result is consumed
//   cancel_i            flush; forces IDLE from any busy or done state
//   mul_signed_i, op_i  signedness; op 00 MUL, 01 MADD, 10 MSUB, 11 behaves as MUL
//   ina, inb, acc_i     multiplicand, multiplier, 2*WIDTH accumulator
//   result_o, ready_o   final result, which is 0 unless ready_o is high
//   busy_o              high in CALC and FIX
module mul_iter_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 cancel_i,
    input  logic                 mul_signed_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     ina,
    input  logic [WIDTH-1:0]     inb,
    input  logic [2*WIDTH-1:0]   acc_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);
    localparam int PW = 2 * WIDTH;
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_mcand;     // multiplicand magnitude, shifted left each step
    logic [WIDTH-1:0] r_mplier;   // multiplier magnitude, shifted right each step
    logic [PW-1:0]   r_partial;
    logic [PW-1:0]   r_acc;
    logic [1:0]      r_op;
    logic            r_neg;       // signed op with differing operand signs
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_result;
    logic            r_ready;
    logic            r_busy;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_product;
    logic [PW-1:0]    w_result;

    // The most-negative value negates to itself. Read as unsigned, that is exactly its magnitude.
    assign w_a_mag = (mul_signed_i && ina[WIDTH-1]) ? -ina : ina;
    assign w_b_mag = (mul_signed_i && inb[WIDTH-1]) ? -inb : inb;

    // Multiplicand times the low BITS_PER_CYCLE multiplier bits, built from shifted copies.
    always_comb begin
        w_addend = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) begin
                w_addend = w_addend + (r_mcand << i);
            end
        end
    end

    assign w_product = r_neg ? -r_partial : r_partial;

    always_comb begin
        case (r_op)
            2'b01:   w_result = r_acc + w_product;
            2'b10:   w_result = r_acc - w_product;
            default: w_result = w_product;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_partial <= '0;
            r_acc     <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else if (cancel_i) begin
            // A flush wins over start in IDLE and over completion in FIX.
            r_state  <= S_IDLE;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                    if (start_i) begin
                        r_mcand   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier  <= w_b_mag;
                        r_acc     <= acc_i;
                        r_op      <= op_i;
                        r_neg     <= mul_signed_i & (ina[WIDTH-1] ^ inb[WIDTH-1]);
                        r_partial <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_partial <= r_partial + w_addend;
                    r_mcand   <= r_mcand << BITS_PER_CYCLE;
                    r_mplier  <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt     <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_result;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (!start_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = r_busy;
endmodule
